// File: rtl/health_pkg.sv
// Shared state encoding and counter-width helper for the health classifier.
package health_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_OK    = 2'd1,
    ST_WARN  = 2'd2,
    ST_FAULT = 2'd3
  } health_state_t;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/health_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module health_sat_counter
  import health_pkg::*;
#(
  parameter  int unsigned MAX = 1,
  localparam int unsigned W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/health_state_fsm.sv
// Heartbeat/error health classifier: INIT/OK/WARN/FAULT with registered LED decode.
module health_state_fsm
  import health_pkg::*;
#(
  parameter int unsigned TIMEOUT_LIMIT = 1000,
  parameter int unsigned FAULT_LIMIT   = 4000,
  parameter int unsigned RECOVER_COUNT = 3,
  parameter int unsigned ERR_FILTER    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       heartbeat,
  input  logic       err_in,
  input  logic       clear,
  output logic       led_ok,
  output logic       blink_en,
  output logic       led_fault,
  output logic [1:0] state
);

  localparam int unsigned IW = cnt_width(FAULT_LIMIT);
  localparam int unsigned EW = cnt_width(ERR_FILTER);
  localparam int unsigned RW = cnt_width(RECOVER_COUNT);

  health_state_t state_q;
  health_state_t state_n;
  logic          state_chg;

  logic [IW-1:0] idle_cnt;
  logic [EW-1:0] err_cnt;
  logic [RW-1:0] recov_cnt;

  logic err_hit;
  logic idle_timeout;
  logic idle_fault;
  logic recov_done;
  logic err_clean;

  // Compare at 32 bits so limits larger than a counter's range never alias.
  assign err_hit      = (32'(err_cnt) == ERR_FILTER - 1) && err_in;
  assign idle_timeout = (32'(idle_cnt) == TIMEOUT_LIMIT - 1) && !heartbeat;
  assign idle_fault   = (32'(idle_cnt) == FAULT_LIMIT - 1) && !heartbeat;
  assign recov_done   = heartbeat && (32'(recov_cnt) == RECOVER_COUNT - 1);
  assign err_clean    = (err_cnt == '0) && !err_in;

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_INIT: begin
        if (err_hit)           state_n = ST_FAULT;
        else if (idle_timeout) state_n = ST_WARN;
        else if (heartbeat)    state_n = ST_OK;
      end
      ST_OK: begin
        if (err_hit)           state_n = ST_FAULT;
        else if (idle_timeout) state_n = ST_WARN;
      end
      ST_WARN: begin
        if (err_hit)           state_n = ST_FAULT;
        else if (idle_fault)   state_n = ST_FAULT;
        else if (recov_done)   state_n = ST_OK;
      end
      ST_FAULT: begin
        if (clear && err_clean) state_n = ST_INIT;
      end
    endcase
  end

  assign state_chg = (state_n != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      led_ok    <= 1'b0;
      blink_en  <= 1'b0;
      led_fault <= 1'b0;
    end else begin
      state_q   <= state_n;
      led_ok    <= (state_n == ST_OK);
      blink_en  <= (state_n == ST_WARN);
      led_fault <= (state_n == ST_FAULT);
    end
  end

  assign state = state_q;

  health_sat_counter #(.MAX(FAULT_LIMIT)) u_idle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!heartbeat),
    .clr   (heartbeat || state_chg),
    .count (idle_cnt)
  );

  health_sat_counter #(.MAX(ERR_FILTER)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_in),
    .clr   (!err_in),
    .count (err_cnt)
  );

  health_sat_counter #(.MAX(RECOVER_COUNT)) u_recov_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (heartbeat && (state_q == ST_WARN)),
    .clr   (state_chg),
    .count (recov_cnt)
  );

endmodule

// File: tb/tb_health_state_fsm.sv
// Directed table-driven bench for health_state_fsm with small limits.
module tb_health_state_fsm;

  logic       clk;
  logic       rst_n;
  logic       heartbeat;
  logic       err_in;
  logic       clear;
  logic       led_ok;
  logic       blink_en;
  logic       led_fault;
  logic [1:0] state;

  int unsigned n_tests;
  int unsigned n_fail;

  typedef struct {
    logic       hb;
    logic       err;
    logic       clr;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  health_state_fsm #(
    .TIMEOUT_LIMIT (4),
    .FAULT_LIMIT   (6),
    .RECOVER_COUNT (2),
    .ERR_FILTER    (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .heartbeat (heartbeat),
    .err_in    (err_in),
    .clear     (clear),
    .led_ok    (led_ok),
    .blink_en  (blink_en),
    .led_fault (led_fault),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic hb, input logic err, input logic clr, input logic [1:0] st);
    vec_t v;
    v.hb = hb; v.err = err; v.clr = clr; v.st = st;
    vecs.push_back(v);
  endtask

  // Expected {state, led_ok, blink_en, led_fault} for a given state code.
  function automatic logic [4:0] expect_of(input logic [1:0] st);
    return {st, st == 2'd1, st == 2'd2, st == 2'd3};
  endfunction

  task automatic check(input string name, input logic [1:0] st);
    logic [4:0] act;
    logic [4:0] exp;
    act = {state, led_ok, blink_en, led_fault};
    exp = expect_of(st);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {state,ok,blink,fault}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic hb, input logic err, input logic clr, input logic [1:0] st,
                      input string name);
    heartbeat = hb;
    err_in    = err;
    clear     = clr;
    @(posedge clk);
    #1;
    check(name, st);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    heartbeat = 1'b0;
    err_in    = 1'b0;
    clear     = 1'b0;

    // Bring-up
    add(0, 0, 0, 2'd0);
    add(0, 0, 0, 2'd0);
    add(1, 0, 0, 2'd1);
    // Timeout from OK on 4th idle edge
    add(0, 0, 0, 2'd1);
    add(0, 0, 0, 2'd1);
    add(0, 0, 0, 2'd1);
    add(0, 0, 0, 2'd2);
    // Recovery: two heartbeats two cycles apart
    add(1, 0, 0, 2'd2);
    add(0, 0, 0, 2'd2);
    add(1, 0, 0, 2'd1);
    // Heartbeat on the exact timeout cycle cancels it
    add(0, 0, 0, 2'd1);
    add(0, 0, 0, 2'd1);
    add(0, 0, 0, 2'd1);
    add(1, 0, 0, 2'd1);
    add(0, 0, 0, 2'd1);
    add(0, 0, 0, 2'd1);
    add(0, 0, 0, 2'd1);
    add(0, 0, 0, 2'd2);
    // Escalation: 6 idle cycles in WARN
    add(0, 0, 0, 2'd2);
    add(0, 0, 0, 2'd2);
    add(0, 0, 0, 2'd2);
    add(0, 0, 0, 2'd2);
    add(0, 0, 0, 2'd2);
    add(0, 0, 0, 2'd3);
    // FAULT is sticky under heartbeats
    add(1, 0, 0, 2'd3);
    add(0, 0, 0, 2'd3);
    add(1, 0, 0, 2'd3);
    // Clear gated by err_in and by err_cnt left over from last cycle
    add(0, 1, 1, 2'd3);
    add(0, 0, 1, 2'd3);
    add(0, 0, 0, 2'd3);
    add(0, 0, 1, 2'd0);
    // Error filter: two high cycles do nothing
    add(1, 0, 0, 2'd1);
    add(0, 1, 0, 2'd1);
    add(0, 1, 0, 2'd1);
    add(1, 0, 0, 2'd1);
    // Three high cycles fault even with a coinciding heartbeat
    add(0, 1, 0, 2'd1);
    add(0, 1, 0, 2'd1);
    add(1, 1, 0, 2'd3);
    add(0, 0, 0, 2'd3);
    add(0, 0, 1, 2'd0);

    #2;
    check("reset_state", 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].hb, vecs[i].err, vecs[i].clr, vecs[i].st, $sformatf("vec%0d", i));
    end

    // INIT times out to WARN, then asynchronous reset mid-WARN
    step(0, 0, 0, 2'd0, "init_idle1");
    step(0, 0, 0, 2'd0, "init_idle2");
    step(0, 0, 0, 2'd0, "init_idle3");
    step(0, 0, 0, 2'd2, "init_timeout");
    step(0, 0, 0, 2'd2, "warn_hold1");
    step(1, 0, 0, 2'd2, "warn_hb1");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 2'd0);
    @(posedge clk);
    #1;
    check("reset_held", 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 2'd0, "post_reset_idle1");
    step(0, 0, 0, 2'd0, "post_reset_idle2");
    step(0, 0, 0, 2'd0, "post_reset_idle3");
    step(0, 0, 0, 2'd2, "post_reset_timeout");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/health_state_fsm.md
# health_state_fsm

Classifies system health from a periodic heartbeat pulse and an error level into INIT / OK / WARN / FAULT and drives the LED stage. It sits directly upstream of `output_driver_blinker`: `blink_en` connects to the blinker's `enable`. The steady indicators `led_ok` and `led_fault` drive LEDs directly.

## Interface
- `TIMEOUT_LIMIT`, default 1000: consecutive heartbeat-free cycles in OK or INIT before entering WARN. Must be ≥1.
- `FAULT_LIMIT`, default 4000: consecutive heartbeat-free cycles in WARN before entering FAULT. Must be ≥1.
- `RECOVER_COUNT`, default 3: heartbeats required in WARN to return to OK. Must be ≥1.
- `ERR_FILTER`, default 8: consecutive cycles `err_in` must be high to count as an error. Must be ≥1.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `heartbeat`, in, 1: single-cycle pulse from the monitored logic, synchronous to `clk`.
- `err_in`, in, 1: error level, synchronous to `clk`.
- `clear`, in, 1: single-cycle pulse requesting exit from FAULT.
- `led_ok`, out, 1: high in OK.
- `blink_en`, out, 1: high in WARN. Feeds the blinker `enable`.
- `led_fault`, out, 1: high in FAULT.
- `state`, out, 2: current state code. INIT=0, OK=1, WARN=2, FAULT=3.

## Operation
- **Reset:**
  - `state`=INIT.
  - All counters are 0.
  - `led_ok`=`blink_en`=`led_fault`=0.
- **idle_cnt:**
  - Increments on every cycle with `heartbeat`=0.
  - Cleared on any `heartbeat`=1 cycle and on every state change.
  - Saturates at FAULT_LIMIT.
- **err_cnt:**
  - Increments while `err_in`=1 and saturates at ERR_FILTER.
  - Cleared on any cycle with `err_in`=0.
  - `err_hit` = (`err_cnt`==ERR_FILTER-1 && `err_in`), i.e. the ERR_FILTER-th consecutive high cycle.
  - `err_cnt` is not cleared by state changes.
- **recov_cnt:**
  - Counts heartbeats while in WARN.
  - Cleared on every state change.
- **Transitions.** Priority within a state is `err_hit` > timeout > heartbeat.
  - INIT:
    - `err_hit` → FAULT.
    - `idle_cnt`==TIMEOUT_LIMIT-1 && !`heartbeat` → WARN.
    - `heartbeat` → OK.
  - OK:
    - `err_hit` → FAULT.
    - `idle_cnt`==TIMEOUT_LIMIT-1 && !`heartbeat` → WARN.
  - WARN:
    - `err_hit` → FAULT.
    - `idle_cnt`==FAULT_LIMIT-1 && !`heartbeat` → FAULT.
    - `heartbeat` && `recov_cnt`==RECOVER_COUNT-1 → OK.
  - FAULT is sticky. `clear` && `err_cnt`==0 && !`err_in` → INIT. `clear` is ignored in all other cases and in all other states.
- **Outputs:**
  - Registered, one-hot decode of the state register. At most one of the three LED outputs is high.
  - All three are 0 in INIT.

## Timing
- A transition takes effect at the rising edge on which its condition is true. `state` and the LED outputs update on that same edge, with no extra pipeline stage.
- Timeout: with the last heartbeat on cycle h, WARN is entered at the edge ending cycle h+TIMEOUT_LIMIT when no heartbeat occurs in between.
- A heartbeat on the exact timeout cycle cancels the timeout.
- `err_hit` coinciding with a heartbeat or timeout → FAULT.
- `rst_n` low at any time:
  - Immediately forces INIT, outputs 0 and counters 0, independent of `clk`.
  - Deassertion is taken as synchronous to `clk`.
- The `blink_en` handoff is level-only. The blinker's own phase is not reset by this block.

## Structure
- Package `health_pkg`:
  - 2-bit state type with INIT/OK/WARN/FAULT codes.
  - Shared width helper based on `$clog2`.
- One natural sub-module, `health_sat_counter`:
  - Parameter MAX.
  - Ports `clk`, `rst_n`, `inc`, `clr` (`clr` wins over `inc`), and `count`.
  - Instantiated three times: idle, err and recov counters.
- The top-level holds the next-state logic and the output register. Target size is about 150–250 lines of RTL.

## Test plan
Parameters for all scenarios: TIMEOUT_LIMIT=4, FAULT_LIMIT=6, RECOVER_COUNT=2, ERR_FILTER=3.

- **Bring-up:** release reset, pulse `heartbeat` on cycle 3 → `state`=1 and `led_ok`=1 after that edge. Outputs are 0 before it.
- **Timeout and recovery:** in OK, hold `heartbeat`=0 for 4 cycles → `blink_en`=1 at the 4th edge. Then send 2 heartbeats 2 cycles apart → OK at the 2nd heartbeat edge, `blink_en`=0.
- **Escalation:** in WARN, no heartbeat for 6 cycles → `state`=3 and `led_fault`=1 at the 6th edge. Random heartbeats afterwards leave FAULT unchanged.
- **Error filter:** in OK, `err_in` high 2 cycles then low → stays OK. `err_in` high 3 cycles → FAULT at the 3rd edge, including when a heartbeat arrives on that cycle.
- **Clear:** in FAULT, pulse `clear` with `err_in`=1 → stays FAULT. Drop `err_in`, wait 1 cycle, pulse `clear` → INIT with all LEDs 0.
- **Reset mid-operation:** assert `rst_n`=0 mid-WARN, between clock edges → outputs 0 and `state`=0 immediately. After release, the timeout counts again from 0.
